sync_fifo: RTL and testbench

Parametrised single-clock FIFO built around an internal dual-port RAM (one write port, one read port), the next generation of the team's dpram-backed FIFO. It adds configurable width and depth, a selectable first-word-fall-through (FWFT) output mode, occupancy count, programmable almost-full/almost-empty flags, and single-cycle overflow/underflow error pulses. It sits between a producer and a consumer in the same clock domain as a general-purpose elastic buffer.

---
 rtl/sync_fifo_if.sv | 33 +++
 rtl/sync_fifo.sv | 135 +++++++++++++
 tb/tb_sync_fifo.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo.
// master drives requests and data; slave is the FIFO.
interface sync_fifo_if #(
  parameter int DATA = 16,
  parameter int ADDR = 5
);
  logic            fifo_WR;
  logic [DATA-1:0] fifo_IN;
  logic            fifo_RD;
  logic [DATA-1:0] fifo_OUT;
  logic            fifo_VALID;
  logic            fifo_FULL;
  logic            fifo_EMPTY;
  logic            fifo_AFULL;
  logic            fifo_AEMPTY;
  logic [ADDR:0]   fifo_COUNT;
  logic            fifo_OVF;
  logic            fifo_UDF;

  modport master (
    output fifo_WR, fifo_IN, fifo_RD,
    input  fifo_OUT, fifo_VALID, fifo_FULL, fifo_EMPTY,
    input  fifo_AFULL, fifo_AEMPTY, fifo_COUNT,
    input  fifo_OVF, fifo_UDF
  );

  modport slave (
    input  fifo_WR, fifo_IN, fifo_RD,
    output fifo_OUT, fifo_VALID, fifo_FULL, fifo_EMPTY,
    output fifo_AFULL, fifo_AEMPTY, fifo_COUNT,
    output fifo_OVF, fifo_UDF
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock dual-port-RAM FIFO with standard or FWFT output,
// occupancy count, almost flags and overflow/underflow pulses.
module sync_fifo #(
  parameter int DATA     = 16,
  parameter int ADDR     = 5,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = (1 << ADDR) - 2,
  parameter int AE_LEVEL = 2
) (
  input logic       clK,
  input logic       rsT,
  sync_fifo_if.slave f
);
  localparam int            CW    = ADDR + 1;
  localparam int            DEPTH = 1 << ADDR;
  localparam logic [ADDR:0] FULL_C = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] AF_L   = CW'(AF_LEVEL);
  localparam logic [ADDR:0] AE_L   = CW'(AE_LEVEL);

  logic [DATA-1:0] mem [DEPTH];

  logic [ADDR-1:0] wptr_q, wptr_d;
  logic [ADDR-1:0] rptr_q, rptr_d;
  logic [ADDR:0]   cnt_q, cnt_d;
  logic [ADDR:0]   rcnt_q, rcnt_d;
  logic            r1_vld_q, r1_vld_d;
  logic [DATA-1:0] r1_dat_q, r1_dat_d;
  logic            vld_q, vld_d;
  logic [DATA-1:0] out_q, out_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            afull_q, afull_d;
  logic            aempty_q, aempty_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            wr_acc;
  logic            pop;
  logic            rd_ok;
  logic            ram_rd;
  logic            out_take;
  logic [DATA-1:0] ram_dat;

  // rcnt counts words still in RAM; cnt also includes FWFT stages
  always_comb begin
    wr_acc   = f.fifo_WR && !full_q;
    ram_dat  = mem[rptr_q];
    rd_ok    = 1'b0;
    pop      = 1'b0;
    ram_rd   = 1'b0;
    out_take = 1'b0;
    if (FWFT != 0) begin
      rd_ok    = vld_q;
      pop      = f.fifo_RD && vld_q;
      out_take = r1_vld_q && (!vld_q || pop);
      ram_rd   = (rcnt_q != '0) && (!r1_vld_q || out_take);
    end else begin
      rd_ok  = !empty_q;
      pop    = f.fifo_RD && !empty_q;
      ram_rd = pop;
    end

    wptr_d = wr_acc ? wptr_q + ADDR'(1) : wptr_q;
    rptr_d = ram_rd ? rptr_q + ADDR'(1) : rptr_q;
    rcnt_d = rcnt_q + CW'(wr_acc) - CW'(ram_rd);
    cnt_d  = cnt_q + CW'(wr_acc) - CW'(pop);

    r1_vld_d = 1'b0;
    r1_dat_d = r1_dat_q;
    if (FWFT != 0) begin
      r1_vld_d = ram_rd || (r1_vld_q && !out_take);
      r1_dat_d = ram_rd ? ram_dat : r1_dat_q;
      vld_d    = out_take || (vld_q && !pop);
      out_d    = out_take ? r1_dat_q : out_q;
    end else begin
      vld_d = pop;
      out_d = pop ? ram_dat : out_q;
    end

    ovf_d    = f.fifo_WR && full_q;
    udf_d    = f.fifo_RD && !rd_ok;
    full_d   = (cnt_d == FULL_C);
    empty_d  = (cnt_d == '0);
    afull_d  = (cnt_d >= AF_L);
    aempty_d = (cnt_d <= AE_L);
  end

  always_ff @(posedge clK) begin
    if (wr_acc) mem[wptr_q] <= f.fifo_IN;
  end

  always_ff @(posedge clK or posedge rsT) begin
    if (rsT) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      r1_vld_q <= 1'b0;
      r1_dat_q <= '0;
      vld_q    <= 1'b0;
      out_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      r1_vld_q <= r1_vld_d;
      r1_dat_q <= r1_dat_d;
      vld_q    <= vld_d;
      out_q    <= out_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign f.fifo_OUT    = out_q;
  assign f.fifo_VALID  = vld_q;
  assign f.fifo_FULL   = full_q;
  assign f.fifo_EMPTY  = empty_q;
  assign f.fifo_AFULL  = afull_q;
  assign f.fifo_AEMPTY = aempty_q;
  assign f.fifo_COUNT  = cnt_q;
  assign f.fifo_OVF    = ovf_q;
  assign f.fifo_UDF    = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: one standard-mode and one FWFT instance.
// Expected words are queued at write time; monitors pop on output.
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATA(16), .ADDR(5)) fs ();
  sync_fifo_if #(.DATA(16), .ADDR(5)) fw ();

  sync_fifo #(.DATA(16), .ADDR(5), .FWFT(0)) u_std (
    .clK(clk), .rsT(rst), .f(fs.slave)
  );
  sync_fifo #(.DATA(16), .ADDR(5), .FWFT(1)) u_fwft (
    .clK(clk), .rsT(rst), .f(fw.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] qs [$];
  logic [15:0] qw [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // count plus the four flags implied by it (AF=30, AE=2)
  task automatic cnt_s(input string nm, input int c);
    chk({nm, "_count"}, int'(fs.fifo_COUNT), c);
    chk({nm, "_full"}, int'(fs.fifo_FULL), int'(c == 32));
    chk({nm, "_empty"}, int'(fs.fifo_EMPTY), int'(c == 0));
    chk({nm, "_afull"}, int'(fs.fifo_AFULL), int'(c >= 30));
    chk({nm, "_aempty"}, int'(fs.fifo_AEMPTY), int'(c <= 2));
  endtask

  task automatic cnt_w(input string nm, input int c);
    chk({nm, "_count"}, int'(fw.fifo_COUNT), c);
    chk({nm, "_full"}, int'(fw.fifo_FULL), int'(c == 32));
    chk({nm, "_empty"}, int'(fw.fifo_EMPTY), int'(c == 0));
  endtask

  logic [15:0] es;
  always @(negedge clk) begin
    if (fs.fifo_VALID) begin
      if (qs.size() == 0) chk("std_unexpected_valid", 1, 0);
      else begin
        es = qs.pop_front();
        chk("std_data", int'(fs.fifo_OUT), int'(es));
      end
    end
  end

  logic [15:0] ew;
  always @(negedge clk) begin
    if (fw.fifo_VALID && fw.fifo_RD) begin
      if (qw.size() == 0) chk("fwft_unexpected_pop", 1, 0);
      else begin
        ew = qw.pop_front();
        chk("fwft_data", int'(fw.fifo_OUT), int'(ew));
      end
    end
  end

  initial begin
    fs.fifo_WR = 1'b0; fs.fifo_RD = 1'b0; fs.fifo_IN = '0;
    fw.fifo_WR = 1'b0; fw.fifo_RD = 1'b0; fw.fifo_IN = '0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    cnt_s("rst", 0);
    chk("rst_valid", int'(fs.fifo_VALID), 0);
    chk("rst_out", int'(fs.fifo_OUT), 0);
    chk("rst_ovf", int'(fs.fifo_OVF), 0);
    chk("rst_udf", int'(fs.fifo_UDF), 0);
    cnt_w("rst_w", 0);
    chk("rst_w_valid", int'(fw.fifo_VALID), 0);

    // fill to full
    for (int i = 0; i < 32; i++) begin
      fs.fifo_WR = 1'b1; fs.fifo_IN = 16'(i); qs.push_back(16'(i));
      tick();
      cnt_s("fill", i + 1);
    end
    fs.fifo_IN = 16'hBEEF;
    tick();
    chk("ovf_pulse", int'(fs.fifo_OVF), 1);
    cnt_s("ovf", 32);
    fs.fifo_WR = 1'b0;
    tick();
    chk("ovf_end", int'(fs.fifo_OVF), 0);

    // drain in order, then underflow
    for (int i = 0; i < 32; i++) begin
      fs.fifo_RD = 1'b1;
      tick();
      cnt_s("drain", 31 - i);
    end
    tick();
    chk("udf_pulse", int'(fs.fifo_UDF), 1);
    chk("udf_valid", int'(fs.fifo_VALID), 0);
    fs.fifo_RD = 1'b0;
    tick();
    chk("udf_end", int'(fs.fifo_UDF), 0);

    // steady concurrency at depth 5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      fs.fifo_WR = 1'b1; fs.fifo_IN = 16'(16'h100 + i);
      qs.push_back(16'(16'h100 + i));
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      fs.fifo_RD = 1'b1; fs.fifo_IN = 16'(16'h105 + i);
      qs.push_back(16'(16'h105 + i));
      tick();
      chk("wrap_count", int'(fs.fifo_COUNT), 5);
      chk("wrap_valid", int'(fs.fifo_VALID), 1);
    end
    fs.fifo_WR = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    fs.fifo_RD = 1'b0;
    tick();
    cnt_s("wrap_end", 0);

    // async reset mid-cycle while half full
    for (int i = 0; i < 16; i++) begin
      fs.fifo_WR = 1'b1; fs.fifo_IN = 16'(16'h400 + i);
      tick();
    end
    fs.fifo_WR = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    cnt_s("arst", 0);
    chk("arst_out", int'(fs.fifo_OUT), 0);
    chk("arst_valid", int'(fs.fifo_VALID), 0);
    @(negedge clk);
    rst = 1'b0;
    fs.fifo_WR = 1'b1; fs.fifo_IN = 16'hA5A5; qs.push_back(16'hA5A5);
    tick();
    cnt_s("post_rst", 1);
    fs.fifo_WR = 1'b0; fs.fifo_RD = 1'b1;
    tick();
    fs.fifo_RD = 1'b0;
    tick();

    // simultaneous write/read at full and at empty
    for (int i = 0; i < 32; i++) begin
      fs.fifo_WR = 1'b1; fs.fifo_IN = 16'(16'h200 + i);
      qs.push_back(16'(16'h200 + i));
      tick();
    end
    fs.fifo_IN = 16'hDEAD; fs.fifo_RD = 1'b1;
    tick();
    chk("full_wr_rd_ovf", int'(fs.fifo_OVF), 1);
    cnt_s("full_wr_rd", 31);
    fs.fifo_WR = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    cnt_s("bnd_drain", 0);
    fs.fifo_WR = 1'b1; fs.fifo_IN = 16'h0777; qs.push_back(16'h0777);
    tick();
    chk("empty_wr_rd_udf", int'(fs.fifo_UDF), 1);
    chk("empty_wr_rd_valid", int'(fs.fifo_VALID), 0);
    cnt_s("empty_wr_rd", 1);
    fs.fifo_WR = 1'b0;
    tick();
    fs.fifo_RD = 1'b0;
    tick();

    // FWFT latency and hold
    fw.fifo_WR = 1'b1; fw.fifo_IN = 16'h1234; qw.push_back(16'h1234);
    tick();
    fw.fifo_WR = 1'b0;
    cnt_w("fw_n", 1);
    chk("fw_n_valid", int'(fw.fifo_VALID), 0);
    tick();
    chk("fw_n1_valid", int'(fw.fifo_VALID), 0);
    tick();
    chk("fw_n2_valid", int'(fw.fifo_VALID), 1);
    chk("fw_n2_out", int'(fw.fifo_OUT), 16'h1234);
    tick();
    chk("fw_hold_valid", int'(fw.fifo_VALID), 1);
    chk("fw_hold_out", int'(fw.fifo_OUT), 16'h1234);
    cnt_w("fw_hold", 1);
    fw.fifo_RD = 1'b1;
    tick();
    chk("fw_rd_valid", int'(fw.fifo_VALID), 0);
    cnt_w("fw_rd", 0);
    tick();
    chk("fw_udf", int'(fw.fifo_UDF), 1);
    fw.fifo_RD = 1'b0;
    tick();
    chk("fw_udf_end", int'(fw.fifo_UDF), 0);

    // FWFT capacity and overflow
    for (int i = 0; i < 32; i++) begin
      fw.fifo_WR = 1'b1; fw.fifo_IN = 16'(16'h300 + i);
      qw.push_back(16'(16'h300 + i));
      tick();
    end
    cnt_w("fw_full", 32);
    fw.fifo_IN = 16'hBEEF;
    tick();
    chk("fw_ovf", int'(fw.fifo_OVF), 1);
    cnt_w("fw_ovf", 32);
    fw.fifo_WR = 1'b0;
    tick();
    chk("fw_ovf_end", int'(fw.fifo_OVF), 0);
    fw.fifo_RD = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("fw_drain_count", int'(fw.fifo_COUNT), 31 - i);
    end
    fw.fifo_RD = 1'b0;
    tick();

    // FWFT sustained one-in/one-out, no bubbles
    for (int i = 0; i < 3; i++) begin
      fw.fifo_WR = 1'b1; fw.fifo_IN = 16'(16'h500 + i);
      qw.push_back(16'(16'h500 + i));
      tick();
    end
    fw.fifo_WR = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      fw.fifo_WR = 1'b1; fw.fifo_RD = 1'b1;
      fw.fifo_IN = 16'(16'h503 + i);
      qw.push_back(16'(16'h503 + i));
      tick();
      chk("fw_stream_valid", int'(fw.fifo_VALID), 1);
      chk("fw_stream_count", int'(fw.fifo_COUNT), 3);
    end
    fw.fifo_WR = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    fw.fifo_RD = 1'b0;
    tick();
    cnt_w("fw_end", 0);
    chk("fw_end_valid", int'(fw.fifo_VALID), 0);

    chk("std_queue_empty", qs.size(), 0);
    chk("fwft_queue_empty", qw.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
